// File: rtl/zap_wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among the code cache,
// the data cache and an auxiliary master (DMA/debug).
//
// Handshake: a beat completes on a rising edge where the owner's stb and the
// slave's i_wb_ack are both high. The ack is routed back only to the owner
// and only while its stb is high; a stray ack with stb low is dropped.
// Ownership lasts for the whole cycle (cyc high), so bursts are never split.
// After the owner drops cyc, one IDLE cycle always follows before the next
// grant, which guarantees a cyc-low gap between owners.
//
// TIMEOUT must be >= 2 and 2**CNT_W must exceed TIMEOUT.
module zap_wb_rr_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  // code master
  input  logic        i_c_wb_cyc,
  input  logic        i_c_wb_stb,
  input  logic        i_c_wb_we,
  input  logic [3:0]  i_c_wb_sel,
  input  logic [31:0] i_c_wb_adr,
  input  logic [31:0] i_c_wb_dat,
  input  logic [2:0]  i_c_wb_cti,
  output logic        o_c_wb_ack,

  // data master
  input  logic        i_d_wb_cyc,
  input  logic        i_d_wb_stb,
  input  logic        i_d_wb_we,
  input  logic [3:0]  i_d_wb_sel,
  input  logic [31:0] i_d_wb_adr,
  input  logic [31:0] i_d_wb_dat,
  input  logic [2:0]  i_d_wb_cti,
  output logic        o_d_wb_ack,

  // auxiliary master
  input  logic        i_x_wb_cyc,
  input  logic        i_x_wb_stb,
  input  logic        i_x_wb_we,
  input  logic [3:0]  i_x_wb_sel,
  input  logic [31:0] i_x_wb_adr,
  input  logic [31:0] i_x_wb_dat,
  input  logic [2:0]  i_x_wb_cti,
  output logic        o_x_wb_ack,

  // shared bus
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,

  // status
  output logic [2:0]  o_grant,
  output logic        o_timeout,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Master indices used by the last-owner pointer.
  localparam logic [1:0] IDX_C = 2'd0;
  localparam logic [1:0] IDX_D = 2'd1;
  localparam logic [1:0] IDX_X = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [2:0] req;
  logic [2:0] stb_vec;
  logic [2:0] winner;
  logic       owner_cyc;
  logic       owner_stb;
  logic       granted;

  assign req       = {i_x_wb_cyc, i_d_wb_cyc, i_c_wb_cyc};
  assign stb_vec   = {i_x_wb_stb, i_d_wb_stb, i_c_wb_stb};
  assign granted   = (state_q == ST_GRANT);
  assign owner_cyc = |(grant_q & req);
  assign owner_stb = |(grant_q & stb_vec);

  assign o_grant     = grant_q;
  assign o_dbg_state = state_q;

  // Rotating priority: search starts at the master after the last owner.
  always_comb begin
    winner = 3'b000;
    unique case (last_q)
      IDX_C: begin
        if      (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      IDX_D: begin
        if      (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if      (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
  end

  // Ownership FSM next-state: grant on any request, release when owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
          if (grant_q[2])      last_d = IDX_X;
          else if (grant_q[1]) last_d = IDX_D;
          else                 last_d = IDX_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // Bus mux from the registered owner; everything is zero while idle.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_sel = 4'h0;
    o_wb_adr = 32'h0;
    o_wb_dat = 32'h0;
    o_wb_cti = 3'b000;
    if (granted) begin
      unique case (grant_q)
        3'b001: begin
          o_wb_cyc = i_c_wb_cyc;
          o_wb_stb = i_c_wb_stb;
          o_wb_we  = i_c_wb_we;
          o_wb_sel = i_c_wb_sel;
          o_wb_adr = i_c_wb_adr;
          o_wb_dat = i_c_wb_dat;
          o_wb_cti = i_c_wb_cti;
        end
        3'b010: begin
          o_wb_cyc = i_d_wb_cyc;
          o_wb_stb = i_d_wb_stb;
          o_wb_we  = i_d_wb_we;
          o_wb_sel = i_d_wb_sel;
          o_wb_adr = i_d_wb_adr;
          o_wb_dat = i_d_wb_dat;
          o_wb_cti = i_d_wb_cti;
        end
        3'b100: begin
          o_wb_cyc = i_x_wb_cyc;
          o_wb_stb = i_x_wb_stb;
          o_wb_we  = i_x_wb_we;
          o_wb_sel = i_x_wb_sel;
          o_wb_adr = i_x_wb_adr;
          o_wb_dat = i_x_wb_dat;
          o_wb_cti = i_x_wb_cti;
        end
        default: ;
      endcase
    end
  end

  // Ack routing: only the owner sees the ack, and only with its stb high.
  always_comb begin
    o_c_wb_ack = granted & grant_q[0] & i_c_wb_stb & i_wb_ack;
    o_d_wb_ack = granted & grant_q[1] & i_d_wb_stb & i_wb_ack;
    o_x_wb_ack = granted & grant_q[2] & i_x_wb_stb & i_wb_ack;
  end

  // Stall counter: counts owner strobe cycles without ack, pulses and wraps.
  always_comb begin
    cnt_d     = '0;
    o_timeout = 1'b0;
    if (granted && owner_stb && !i_wb_ack) begin
      if (cnt_q == CNT_LAST) begin
        o_timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, grant, last-owner and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      last_q  <= IDX_X;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_zap_wb_rr_arbiter.sv
// Bench for zap_wb_rr_arbiter: directed scenarios plus a randomized run
// against a behavioural owner/queue model.
module tb_zap_wb_rr_arbiter;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  // master-side stimulus, index 0 = code, 1 = data, 2 = aux
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [3:0]  sel [3];
  logic [31:0] adr [3];
  logic [31:0] dat [3];
  logic [2:0]  cti [3];
  logic        i_wb_ack;

  logic        o_c_ack, o_d_ack, o_x_ack;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [2:0]  o_wb_cti;
  logic [2:0]  o_grant;
  logic        o_timeout;
  logic        o_dbg_state;
  logic [2:0]  ack_v;
  assign ack_v = {o_x_ack, o_d_ack, o_c_ack};

  int n_cmp = 0;
  int n_fail = 0;

  zap_wb_rr_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_c_wb_cyc(cyc[0]), .i_c_wb_stb(stb[0]), .i_c_wb_we(we[0]), .i_c_wb_sel(sel[0]),
    .i_c_wb_adr(adr[0]), .i_c_wb_dat(dat[0]), .i_c_wb_cti(cti[0]), .o_c_wb_ack(o_c_ack),
    .i_d_wb_cyc(cyc[1]), .i_d_wb_stb(stb[1]), .i_d_wb_we(we[1]), .i_d_wb_sel(sel[1]),
    .i_d_wb_adr(adr[1]), .i_d_wb_dat(dat[1]), .i_d_wb_cti(cti[1]), .o_d_wb_ack(o_d_ack),
    .i_x_wb_cyc(cyc[2]), .i_x_wb_stb(stb[2]), .i_x_wb_we(we[2]), .i_x_wb_sel(sel[2]),
    .i_x_wb_adr(adr[2]), .i_x_wb_dat(dat[2]), .i_x_wb_cti(cti[2]), .o_x_wb_ack(o_x_ack),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_cti(o_wb_cti), .i_wb_ack(i_wb_ack),
    .o_grant(o_grant), .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  // Owner is -1 when nobody holds the bus. Stall is the number of consecutive
  // unacked strobe cycles, modulo TIMEOUT.
  int m_owner = -1;
  int m_last  = 2;
  int m_stall = 0;

  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      m_owner <= -1;
      m_last  <= 2;
      m_stall <= 0;
    end else if (m_owner < 0) begin
      m_stall <= 0;
      // nearest requester after the last owner wins (lowest distance written last)
      for (int k = 3; k >= 1; k--)
        if (cyc[(m_last + k) % 3]) m_owner <= (m_last + k) % 3;
    end else begin
      if (stb[m_owner] && !i_wb_ack) m_stall <= (m_stall + 1) % TIMEOUT;
      else                           m_stall <= 0;
      if (!cyc[m_owner]) begin
        m_last  <= m_owner;
        m_owner <= -1;
      end
    end
  end

  logic [2:0]  e_grant, e_ack;
  logic        e_cyc, e_stb, e_we, e_timeout;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_dat;
  logic [2:0]  e_cti;
  always_comb begin
    e_grant = '0; e_ack = '0; e_cyc = 0; e_stb = 0; e_we = 0; e_timeout = 0;
    e_sel = '0; e_adr = '0; e_dat = '0; e_cti = '0;
    if (m_owner >= 0) begin
      e_grant = 3'(1 << m_owner);
      e_cyc = cyc[m_owner]; e_stb = stb[m_owner]; e_we = we[m_owner];
      e_sel = sel[m_owner]; e_adr = adr[m_owner]; e_dat = dat[m_owner];
      e_cti = cti[m_owner];
      e_ack[m_owner] = stb[m_owner] & i_wb_ack;
      e_timeout = stb[m_owner] && !i_wb_ack && (m_stall == TIMEOUT - 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = '0;
      adr[k] = '0; dat[k] = '0; cti[k] = '0;
    end
    i_wb_ack = 0;
  endtask

  task automatic apply_reset();
    idle_all();
    i_reset_n = 0;
    next_cycle();
    next_cycle();
    i_reset_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 1; stb[k] = 1; adr[k] = 32'hA000_0000 + k;
    end
    i_wb_ack = 1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      n_cmp++; if ({o_wb_cyc, o_wb_stb, o_wb_adr} !== 34'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", {o_wb_cyc, o_wb_stb, o_wb_adr}); end
      n_cmp++; if ({o_grant, ack_v, o_timeout} !== 7'h0) begin n_fail++; $display("FAIL reset_grant_ack: got %b want 0", {o_grant, ack_v, o_timeout}); end
    end
    next_cycle();
    i_reset_n = 1;
    i_wb_ack = 0;
    sample();
    n_cmp++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL reset_release_idle: got %b want 000", o_grant); end
    next_cycle();
    sample();
    n_cmp++; if (o_grant !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 001", o_grant); end
    n_cmp++; if (o_wb_adr !== 32'hA000_0000) begin n_fail++; $display("FAIL reset_first_adr: got %h want a0000000", o_wb_adr); end
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_single_write();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h1000; dat[1] = 32'hDEADBEEF;
    sel[1] = 4'hF; cti[1] = 3'b111;
    sample();
    n_cmp++; if ({o_grant, o_wb_cyc} !== 4'b0000) begin n_fail++; $display("FAIL sw_req_cycle: got %b want 0000", {o_grant, o_wb_cyc}); end
    next_cycle();
    sample();
    n_cmp++; if (o_grant !== 3'b010) begin n_fail++; $display("FAIL sw_grant: got %b want 010", o_grant); end
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat} !== {3'b111, 4'hF, 32'h1000, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL sw_bus: got %h want %h", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat}, {3'b111, 4'hF, 32'h1000, 32'hDEADBEEF}); end
    n_cmp++; if (ack_v !== 3'b000) begin n_fail++; $display("FAIL sw_ack_c1: got %b want 000", ack_v); end
    next_cycle();
    stb[1] = 0; i_wb_ack = 1;   // stray ack with stb low
    sample();
    n_cmp++; if (ack_v !== 3'b000) begin n_fail++; $display("FAIL sw_stray_ack: got %b want 000", ack_v); end
    next_cycle();
    stb[1] = 1; i_wb_ack = 1;
    sample();
    n_cmp++; if (ack_v !== 3'b010) begin n_fail++; $display("FAIL sw_ack_c3: got %b want 010", ack_v); end
    next_cycle();
    cyc[1] = 0; stb[1] = 0; i_wb_ack = 0;
    sample();
    n_cmp++; if ({o_grant, o_wb_cyc, ack_v} !== 7'b010_0_000) begin n_fail++; $display("FAIL sw_drop: got %b want 0100000", {o_grant, o_wb_cyc, ack_v}); end
    next_cycle();
    sample();
    n_cmp++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL sw_release: got %b want 000", o_grant); end
    next_cycle();
    idle_all();
  endtask

  task automatic test_burst();
    // last owner is data; code must win over data and keep the whole burst
    cyc[0] = 1; stb[0] = 1; cti[0] = 3'b010; adr[0] = 32'h2000;
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'h3000;
    sample();
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      adr[0] = 32'h2000 + 32'(4 * b);
      cti[0] = (b == 3) ? 3'b111 : 3'b010;
      i_wb_ack = 1;
      sample();
      n_cmp++; if ({o_grant, ack_v} !== 6'b001_001) begin n_fail++; $display("FAIL burst_beat%0d_grant_ack: got %b want 001001", b, {o_grant, ack_v}); end
      n_cmp++; if ({o_wb_cti, o_wb_adr} !== {cti[0], 32'h2000 + 32'(4 * b)}) begin n_fail++; $display("FAIL burst_beat%0d_bus: got %h want %h", b, {o_wb_cti, o_wb_adr}, {cti[0], 32'h2000 + 32'(4 * b)}); end
    end
    next_cycle();
    cyc[0] = 0; stb[0] = 0; i_wb_ack = 0;
    sample();
    n_cmp++; if ({o_grant, o_wb_cyc} !== 4'b001_0) begin n_fail++; $display("FAIL burst_drop: got %b want 0010", {o_grant, o_wb_cyc}); end
    next_cycle();
    sample();
    n_cmp++; if ({o_grant, o_wb_cyc} !== 4'b000_0) begin n_fail++; $display("FAIL burst_gap: got %b want 0000", {o_grant, o_wb_cyc}); end
    next_cycle();
    sample();
    n_cmp++; if ({o_grant, o_wb_cyc, o_wb_adr} !== {4'b010_1, 32'h3000}) begin n_fail++; $display("FAIL burst_next_owner: got %h want %h", {o_grant, o_wb_cyc, o_wb_adr}, {4'b010_1, 32'h3000}); end
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [2:0] exp_q[$];
    logic [2:0] g, prev_g, acked;
    int gap, got;
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    for (int k = 0; k < 3; k++) begin cyc[k] = 1; stb[k] = 1; end
    i_wb_ack = 1;
    prev_g = '0; gap = 0; got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      sample();
      g = o_grant;
      acked = ack_v;
      if (g != 3'b000 && prev_g == 3'b000) begin
        n_cmp++; if (g !== exp_q[0]) begin n_fail++; $display("FAIL fair_order%0d: got %b want %b", got, g, exp_q[0]); end
        if (got > 0) begin
          n_cmp++; if (gap !== 1) begin n_fail++; $display("FAIL fair_gap%0d: got %0d want 1", got, gap); end
        end
        void'(exp_q.pop_front());
        got++;
        gap = 0;
      end
      if (g == 3'b000) begin
        gap++;
        n_cmp++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL fair_gap_cyc: got %b want 0", o_wb_cyc); end
      end
      prev_g = g;
      next_cycle();
      for (int k = 0; k < 3; k++) begin
        if (acked[k]) begin cyc[k] = 0; stb[k] = 0; end
        else if (!cyc[k]) begin cyc[k] = 1; stb[k] = 1; end
      end
    end
    n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL fair_budget: got %0d grants want 4", got); end
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_timeout();
    cyc[2] = 1; stb[2] = 1; adr[2] = 32'h4000; i_wb_ack = 0;
    sample();
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      sample();
      n_cmp++; if ({o_grant, o_timeout} !== {3'b100, (c % 4) == 0}) begin n_fail++; $display("FAIL timeout_c%0d: got %b want %b", c, {o_grant, o_timeout}, {3'b100, (c % 4) == 0}); end
    end
    next_cycle();
    i_wb_ack = 1;
    sample();
    n_cmp++; if ({ack_v, o_timeout} !== 4'b100_0) begin n_fail++; $display("FAIL timeout_final_ack: got %b want 1000", {ack_v, o_timeout}); end
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    cyc[1] = 1; stb[1] = 1; cti[1] = 3'b010; adr[1] = 32'h5000;
    sample();
    next_cycle();
    i_wb_ack = 1;
    sample();
    n_cmp++; if ({o_grant, ack_v} !== 6'b010_010) begin n_fail++; $display("FAIL rmb_beat1: got %b want 010010", {o_grant, ack_v}); end
    next_cycle();
    i_wb_ack = 0; i_reset_n = 0; adr[1] = 32'h5004;
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h6000;
    sample();
    next_cycle();
    i_wb_ack = 1;
    sample();
    n_cmp++; if ({o_wb_cyc, o_grant, ack_v} !== 7'b0) begin n_fail++; $display("FAIL rmb_in_reset: got %b want 0000000", {o_wb_cyc, o_grant, ack_v}); end
    next_cycle();
    i_reset_n = 1; i_wb_ack = 0;
    sample();
    n_cmp++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL rmb_release_idle: got %b want 000", o_grant); end
    next_cycle();
    sample();
    n_cmp++; if ({o_grant, o_wb_adr} !== {3'b001, 32'h6000}) begin n_fail++; $display("FAIL rmb_code_first: got %h want %h", {o_grant, o_wb_adr}, {3'b001, 32'h6000}); end
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_random();
    int beats [3];
    logic [2:0] acked;
    apply_reset();
    for (int k = 0; k < 3; k++) beats[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      sample();
      n_cmp++; if (o_grant !== e_grant) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, o_grant, e_grant); end
      n_cmp++; if (ack_v !== e_ack) begin n_fail++; $display("FAIL rand_ack c%0d: got %b want %b", c, ack_v, e_ack); end
      n_cmp++; if (o_timeout !== e_timeout) begin n_fail++; $display("FAIL rand_timeout c%0d: got %b want %b", c, o_timeout, e_timeout); end
      n_cmp++; if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat, o_wb_cti} !== {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat, e_cti}) begin
        n_fail++; $display("FAIL rand_bus c%0d: got %h want %h", c, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat, o_wb_cti}, {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat, e_cti}); end
      acked = e_ack;
      next_cycle();
      for (int k = 0; k < 3; k++) begin
        if (cyc[k]) begin
          if (acked[k]) begin
            beats[k]--;
            if (beats[k] == 0) begin
              cyc[k] = 0; stb[k] = 0;
            end else begin
              adr[k] = $urandom; dat[k] = $urandom;
              cti[k] = (beats[k] == 1) ? 3'b111 : 3'b010;
              stb[k] = ($urandom_range(0, 3) != 0);
            end
          end else if (!stb[k]) begin
            stb[k] = 1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          beats[k] = $urandom_range(1, 4);
          cyc[k] = 1; stb[k] = 1;
          we[k] = 1'($urandom_range(0, 1));
          sel[k] = 4'($urandom);
          adr[k] = $urandom; dat[k] = $urandom;
          cti[k] = (beats[k] == 1) ? 3'b111 : 3'b010;
        end
      end
      i_wb_ack = ($urandom_range(0, 1) == 1);
    end
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    i_reset_n = 0;
    test_reset();
    test_single_write();
    test_burst();
    test_fairness();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
